// File: rtl/keypad_code_entry_pkg.sv
// Shared types and constants for the keypad code-entry block: scanner state
// encoding, key codes and the row/column to key-code map.
package keypad_code_entry_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } scan_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_NONE = 4'hA;

    // Letter column (A-D) maps to KEY_NONE so the consumer simply ignores it.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_NONE;
        if (col == 2'd3) begin
            code = KEY_NONE;
        end else if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows_n[0])      idx = 2'd0;
        else if (!rows_n[1]) idx = 2'd1;
        else if (!rows_n[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_code_entry_scanner.sv
// Keypad scanner: row synchronizer, column rotation, press/release debounce,
// and a one-cycle key strobe with the decoded key code.
module keypad_scanner
    import keypad_code_entry_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row_n,
    output logic [3:0] o_col_n,
    output logic       o_key_strobe,
    output logic [3:0] o_key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      r_state;
    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_key_strobe;
    logic [3:0]       r_key_code;

    logic w_any_low;
    logic w_latched_low;

    assign w_any_low     = ~&r_row_sync;
    assign w_latched_low = ~r_row_sync[r_row_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign o_col_n[gi] = (r_col_idx != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SCAN;
            r_row_meta   <= 4'hF;
            r_row_sync   <= 4'hF;
            r_col_idx    <= 2'd0;
            r_row_idx    <= 2'd0;
            r_div_cnt    <= '0;
            r_deb_cnt    <= '0;
            r_key_strobe <= 1'b0;
            r_key_code   <= KEY_NONE;
        end else begin
            r_row_meta   <= i_row_n;
            r_row_sync   <= r_row_meta;
            r_key_strobe <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        if (w_any_low) begin
                            r_row_idx <= lowest_low_row(r_row_sync);
                            r_deb_cnt <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_latched_low) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            r_key_strobe <= 1'b1;
                            r_key_code   <= key_lookup(r_row_idx, r_col_idx);
                            r_deb_cnt    <= '0;
                            r_state      <= WAIT_RELEASE;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        r_div_cnt <= '0;
                        r_state   <= SCAN;
                    end
                end
                WAIT_RELEASE: begin
                    // Any bounce back to low restarts the release window.
                    if (!w_latched_low) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            r_deb_cnt <= '0;
                            r_div_cnt <= '0;
                            r_col_idx <= r_col_idx + 2'd1;
                            r_state   <= SCAN;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        r_deb_cnt <= '0;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign o_key_strobe = r_key_strobe;
    assign o_key_code   = r_key_code;

endmodule

// File: rtl/keypad_code_entry.sv
// 3-digit keypad code entry: buffers digits from the scanner, presents a
// completed code until acknowledged, and discards stale partial entries.
module keypad_code_entry
    import keypad_code_entry_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    input  logic       code_ack,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       code_valid,
    output logic       entry_error,
    output logic [1:0] digit_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             w_key_strobe;
    logic [3:0]       w_key_code;
    logic [3:0]       r_digit1, r_digit2, r_digit3;
    logic [1:0]       r_digit_count;
    logic             r_code_valid;
    logic             r_entry_error;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_clear, w_store, w_set_valid, w_error, w_tmo_clear, w_tmo_inc;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scanner (
        .clk          (clk),
        .rst          (rst),
        .i_row_n      (row_n),
        .o_col_n      (col_n),
        .o_key_strobe (w_key_strobe),
        .o_key_code   (w_key_code)
    );

    // Priority: acknowledge beats a key event, a key event beats timeout.
    always_comb begin
        w_clear     = 1'b0;
        w_store     = 1'b0;
        w_set_valid = 1'b0;
        w_error     = 1'b0;
        w_tmo_clear = 1'b0;
        w_tmo_inc   = 1'b0;
        if (code_ack && r_code_valid) begin
            w_clear     = 1'b1;
            w_tmo_clear = 1'b1;
        end else if (w_key_strobe) begin
            w_tmo_clear = 1'b1;
            if (w_key_code == KEY_STAR) begin
                w_clear = 1'b1;
            end else if (w_key_code == KEY_HASH) begin
                if (r_digit_count == 2'd3) begin
                    w_set_valid = 1'b1;
                end else begin
                    w_clear = 1'b1;
                    w_error = 1'b1;
                end
            end else if (w_key_code <= 4'd9 && r_digit_count != 2'd3 && !r_code_valid) begin
                w_store = 1'b1;
            end
        end else if (r_digit_count != 2'd0 && !r_code_valid) begin
            if (r_tmo_cnt == TMO_LAST) begin
                w_clear     = 1'b1;
                w_error     = 1'b1;
                w_tmo_clear = 1'b1;
            end else begin
                w_tmo_inc = 1'b1;
            end
        end else begin
            w_tmo_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit1      <= 4'd0;
            r_digit2      <= 4'd0;
            r_digit3      <= 4'd0;
            r_digit_count <= 2'd0;
            r_code_valid  <= 1'b0;
            r_entry_error <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            r_entry_error <= w_error;
            if (w_tmo_clear) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_clear) begin
                r_digit1      <= 4'd0;
                r_digit2      <= 4'd0;
                r_digit3      <= 4'd0;
                r_digit_count <= 2'd0;
                r_code_valid  <= 1'b0;
            end else begin
                if (w_set_valid) begin
                    r_code_valid <= 1'b1;
                end
                if (w_store) begin
                    case (r_digit_count)
                        2'd0:    r_digit1 <= w_key_code;
                        2'd1:    r_digit2 <= w_key_code;
                        default: r_digit3 <= w_key_code;
                    endcase
                    r_digit_count <= r_digit_count + 2'd1;
                end
            end
        end
    end

    assign digit1      = r_digit1;
    assign digit2      = r_digit2;
    assign digit3      = r_digit3;
    assign digit_count = r_digit_count;
    assign code_valid  = r_code_valid;
    assign entry_error = r_entry_error;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench: a keypad model drives rows from the column drive, and
// a scoreboard compares every change of the visible state with the queue.
module tb_keypad_code_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int TMO      = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       code_ack = 1'b0;
    logic [3:0] digit1, digit2, digit3;
    logic       code_valid, entry_error;
    logic [1:0] digit_count;

    keypad_code_entry #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n       (row_n),
        .col_n       (col_n),
        .code_ack    (code_ack),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .code_valid  (code_valid),
        .entry_error (entry_error),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key shorts its row to its column when driven low.
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic       glitch = 1'b0;
    always_comb begin
        row_n = 4'hF;
        if (key_down && col_n[key_c] == 1'b0) row_n[key_r] = 1'b0;
        if (glitch) row_n[0] = 1'b0;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] st(input logic err, input logic v, input logic [1:0] n,
                                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {err, v, n, a, b, c};
    endfunction

    logic [15:0] exp_q[$];
    logic [15:0] obs;
    logic [15:0] prev_obs;
    logic [15:0] sb_exp;
    logic        mon_en = 1'b0;
    assign obs = {entry_error, code_valid, digit_count, digit1, digit2, digit3};

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_obs[15]) check_eq("err_width", 32'(obs[15]), 32'd0);
                if (obs != prev_obs) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_unexpected", 32'(obs), 32'(prev_obs));
                    end else begin
                        sb_exp = exp_q.pop_front();
                        $display("sb: t=%0t state err/valid/cnt/digits 0x%04h expected 0x%04h", $time, obs, sb_exp);
                        check_eq("sb_state", 32'(obs), 32'(sb_exp));
                    end
                end
                prev_obs = obs;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the start of column c's slot so a press lines up with the scan.
    task automatic wait_col_start(input logic [1:0] c);
        int t;
        t = 0;
        while (col_n[c] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        while (col_n[c] !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check_eq("col_wait", 32'(t), 32'd0);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        wait_col_start(c);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
        wait_cycles(20);
        key_down = 1'b0;
        wait_cycles(24);
        $display("press: row %0d col %0d released at t=%0t", r, c, $time);
    endtask

    task automatic ack_pulse();
        code_ack = 1'b1;
        @(negedge clk);
        code_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_col;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        wait_cycles(3);
        check_eq("rst_col_n",  32'(col_n), 32'hE);
        check_eq("rst_count",  32'(digit_count), 32'd0);
        check_eq("rst_valid",  32'(code_valid), 32'd0);
        check_eq("rst_error",  32'(entry_error), 32'd0);
        check_eq("rst_digits", 32'({digit1, digit2, digit3}), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check_eq("scan_col", 32'(col_n), 32'(exp_col));
        end
        prev_obs = obs;
        mon_en   = 1'b1;

        // Short glitch on row0 during column 0 must not produce a key.
        wait_col_start(2'd0);
        glitch = 1'b1;
        wait_cycles(3);
        glitch = 1'b0;
        wait_cycles(30);
        check_eq("glitch_count", 32'(digit_count), 32'd0);

        // 4, 7, 2, A (ignored), # then acknowledge.
        exp_q.push_back(st(0, 0, 2'd1, 4'd4, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd2, 4'd4, 4'd7, 4'd0));
        exp_q.push_back(st(0, 0, 2'd3, 4'd4, 4'd7, 4'd2));
        press(2'd1, 2'd0);
        press(2'd2, 2'd0);
        press(2'd0, 2'd1);
        press(2'd0, 2'd3);
        exp_q.push_back(st(0, 1, 2'd3, 4'd4, 4'd7, 4'd2));
        press(2'd3, 2'd2);
        check_eq("code_valid_set", 32'(code_valid), 32'd1);
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        ack_pulse();
        check_eq("ack_valid", 32'(code_valid), 32'd0);
        check_eq("ack_count", 32'(digit_count), 32'd0);

        // 1, 2, # : short code is an error.
        exp_q.push_back(st(0, 0, 2'd1, 4'd1, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd2, 4'd1, 4'd2, 4'd0));
        exp_q.push_back(st(1, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        press(2'd3, 2'd2);
        check_eq("short_valid", 32'(code_valid), 32'd0);

        // 5 then idle: timeout discards the partial entry.
        exp_q.push_back(st(0, 0, 2'd1, 4'd5, 4'd0, 4'd0));
        exp_q.push_back(st(1, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        press(2'd1, 2'd1);
        wait_cycles(260);
        check_eq("tmo_count", 32'(digit_count), 32'd0);

        // 1, 2, 3, # then long idle: a presented code never times out.
        exp_q.push_back(st(0, 0, 2'd1, 4'd1, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd2, 4'd1, 4'd2, 4'd0));
        exp_q.push_back(st(0, 0, 2'd3, 4'd1, 4'd2, 4'd3));
        exp_q.push_back(st(0, 1, 2'd3, 4'd1, 4'd2, 4'd3));
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        press(2'd0, 2'd2);
        press(2'd3, 2'd2);
        wait_cycles(1000);
        check_eq("hold_valid", 32'(code_valid), 32'd1);
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        ack_pulse();

        // 9, 8, 7, 6 (dropped), # then '*'.
        exp_q.push_back(st(0, 0, 2'd1, 4'd9, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd2, 4'd9, 4'd8, 4'd0));
        exp_q.push_back(st(0, 0, 2'd3, 4'd9, 4'd8, 4'd7));
        press(2'd2, 2'd2);
        press(2'd2, 2'd1);
        press(2'd2, 2'd0);
        press(2'd1, 2'd2);
        exp_q.push_back(st(0, 1, 2'd3, 4'd9, 4'd8, 4'd7));
        press(2'd3, 2'd2);
        check_eq("four_digits", 32'({digit1, digit2, digit3}), 32'h987);
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        press(2'd3, 2'd0);
        check_eq("star_valid", 32'(code_valid), 32'd0);

        // 8, then hold 3 across a reset mid-debounce.
        exp_q.push_back(st(0, 0, 2'd1, 4'd8, 4'd0, 4'd0));
        press(2'd2, 2'd1);
        exp_q.push_back(st(0, 0, 2'd0, 4'd0, 4'd0, 4'd0));
        exp_q.push_back(st(0, 0, 2'd1, 4'd3, 4'd0, 4'd0));
        wait_col_start(2'd2);
        key_r    = 2'd0;
        key_c    = 2'd2;
        key_down = 1'b1;
        wait_cycles(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(60);
        key_down = 1'b0;
        wait_cycles(30);
        check_eq("rst_hold_count", 32'(digit_count), 32'd1);
        check_eq("rst_hold_digit", 32'(digit1), 32'd3);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
